// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder: default sizes, FSM
// state encoding and lane slicing helper.
// Latency: n/a. Backpressure: n/a.
package systolic_pkg;

    // Default array dimension and operand width per lane.
    localparam int DEF_N  = 4;
    localparam int DEF_DW = 16;

    // Feeder FSM encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bit offset of lane 'lane' inside a packed vector of dw-wide lanes.
    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Purpose: DEPTH-stage register shift line, one lane of the edge skew.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; shifts every cycle.
// Ports: clk, rst_n (async active-low), din (DW), dout (DW).
module skew_delay_line
    import systolic_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int DW    = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage[s] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int s = 1; s < DEPTH; s++) begin
                stage[s] <= stage[s-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Purpose: feeds west/north edges of an NxN output-stationary systolic array
//          with lane i skewed by i cycles, sequencing PE enable and done.
// Latency: accepted beat reaches lane i of both edges i+1 cycles later.
// Backpressure: in_ready high only in LOAD; stalls (in_valid low) insert zero bubbles.
// Ports: clk, rst_n, start, cfg_k, in_valid/in_ready, a_vec/b_vec (beat in),
//        a_edge/b_edge (skewed edges out), pe_enable, busy, done.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW,
    parameter int KW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [KW-1:0]   cfg_k,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] a_vec,
    input  logic [N*DW-1:0] b_vec,
    output logic [N*DW-1:0] a_edge,
    output logic [N*DW-1:0] b_edge,
    output logic            pe_enable,
    output logic            busy,
    output logic            done
);

    // Drain covers N-1 lane-skew hops plus N-1 PE forwarding hops.
    localparam int             DRAIN      = 2 * N - 2;
    localparam int             DCW        = $clog2(DRAIN + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN - 1);
    localparam logic [KW-1:0]  K_ONE      = KW'(1);

    state_t          state;
    state_t          state_nx;
    logic [KW-1:0]   k_lat;
    logic [KW-1:0]   beat_cnt;
    logic [DCW-1:0]  drain_cnt;
    logic            accept;
    logic            last_beat;
    logic            drain_end;
    logic [N*DW-1:0] a_stage;
    logic [N*DW-1:0] b_stage;

    assign in_ready  = (state == LOAD);
    assign busy      = (state != IDLE);
    assign accept    = in_ready && in_valid;
    // k_lat is never 0 in LOAD, so k_lat-1 cannot underflow here.
    assign last_beat = accept && (beat_cnt == k_lat - K_ONE);
    assign drain_end = (state == FLUSH) && (drain_cnt == DRAIN_LAST);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (cfg_k == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (last_beat) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (drain_end) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ---------------- job counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_lat     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            // start is only honoured in IDLE; a start during a job leaves k_lat alone.
            if ((state == IDLE) && start) begin
                k_lat    <= cfg_k;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + K_ONE;
            end

            if (state == FLUSH) begin
                drain_cnt <= drain_cnt + DCW'(1);
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    // ---------------- registered status outputs ----------------
    // Both are registered from the state, so the enable window trails the
    // LOAD/FLUSH states by one cycle, matching the lane-0 data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_enable <= 1'b0;
            done      <= 1'b0;
        end else begin
            pe_enable <= (state == LOAD) || (state == FLUSH);
            done      <= (state == DONE);
        end
    end

    // ---------------- data path ----------------
    // Lane-0 register for every lane: captures the beat on acceptance and
    // zeros otherwise, so bubbles and drain inject zero operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_stage <= '0;
            b_stage <= '0;
        end else begin
            a_stage <= accept ? a_vec : '0;
            b_stage <= accept ? b_vec : '0;
        end
    end

    assign a_edge[lane_lsb(0, DW) +: DW] = a_stage[lane_lsb(0, DW) +: DW];
    assign b_edge[lane_lsb(0, DW) +: DW] = b_stage[lane_lsb(0, DW) +: DW];

    // Lanes 1..N-1 add i more registers after the shared input stage.
    for (genvar i = 1; i < N; i++) begin : g_lane
        skew_delay_line #(
            .DEPTH (i),
            .DW    (DW)
        ) u_a_dly (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (a_stage[lane_lsb(i, DW) +: DW]),
            .dout  (a_edge[lane_lsb(i, DW) +: DW])
        );

        skew_delay_line #(
            .DEPTH (i),
            .DW    (DW)
        ) u_b_dly (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (b_stage[lane_lsb(i, DW) +: DW]),
            .dout  (b_edge[lane_lsb(i, DW) +: DW])
        );
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Purpose: self-checking bench for systolic_skew_feeder with a 4x4 PE array model.
// Latency: n/a.
// Backpressure: drives in_valid stalls and start pokes while busy.
module tb_systolic_skew_feeder;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int KW = 16;
    localparam int W  = N * DW;
    localparam logic [W-1:0] GARB = 64'hDEAD_BEEF_CAFE_F00D;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [KW-1:0] cfg_k;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a_vec;
    logic [W-1:0]  b_vec;
    logic [W-1:0]  a_edge;
    logic [W-1:0]  b_edge;
    logic          pe_enable;
    logic          busy;
    logic          done;

    systolic_skew_feeder #(.N(N), .DW(DW), .KW(KW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_k     (cfg_k),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_vec     (a_vec),
        .b_vec     (b_vec),
        .a_edge    (a_edge),
        .b_edge    (b_edge),
        .pe_enable (pe_enable),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    int edges  = 0;
    int en_cnt, rdy_cnt, done_cnt, done_at;
    logic last_acc;

    typedef struct {
        int            due;
        int            lane;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } sb_t;
    sb_t q[$];

    typedef struct {
        int k;
        int gap;
        int pat;
        int poke;
        int exp_en;
        int exp_rdy;
        int exp_lat;
    } job_t;
    job_t jobs[6];

    // ---------------- 4x4 output-stationary PE array model ----------------
    logic          pe_clr = 1'b0;
    logic [DW-1:0] pa   [N][N];
    logic [DW-1:0] pb   [N][N];
    logic [31:0]   pacc [N][N];

    always @(negedge clk) begin
        logic [DW-1:0] ain;
        logic [DW-1:0] bin;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) ain = a_edge[i*DW +: DW];
                else        ain = pa[i][j-1];
                if (i == 0) bin = b_edge[j*DW +: DW];
                else        bin = pb[i-1][j];
                if (pe_clr) begin
                    pa[i][j]   <= '0;
                    pb[i][j]   <= '0;
                    pacc[i][j] <= '0;
                end else if (pe_enable) begin
                    pa[i][j]   <= ain;
                    pb[i][j]   <= bin;
                    pacc[i][j] <= pacc[i][j] + 32'(ain) * 32'(bin);
                end
            end
        end
    end

    // ---------------- reference functions ----------------
    function automatic logic [DW-1:0] beat_lane(input int pat, input int b, input int lane, input bit is_a);
        if (pat == 0) begin
            if (is_a) return (lane == b) ? DW'(1) : DW'(0);
            else      return DW'(b * N + lane + 1);
        end else begin
            if (is_a) return DW'(N - lane);
            else      return DW'(2 * N - lane);
        end
    endfunction

    function automatic logic [W-1:0] beat_vec(input int pat, input int b, input bit is_a);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = beat_lane(pat, b, i, is_a);
        return v;
    endfunction

    function automatic logic [31:0] exp_acc(input int pat, input int k, input int i, input int j);
        int s;
        s = 0;
        for (int b = 0; b < k; b++) s += int'(beat_lane(pat, b, i, 1'b1)) * int'(beat_lane(pat, b, j, 1'b0));
        return 32'(s);
    endfunction

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_edges();
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
        exp_a = '0;
        exp_b = '0;
        for (int n = q.size() - 1; n >= 0; n--) begin
            if (q[n].due <= edges) begin
                if (q[n].due == edges) begin
                    exp_a[q[n].lane*DW +: DW] = q[n].a;
                    exp_b[q[n].lane*DW +: DW] = q[n].b;
                end
                q.delete(n);
            end
        end
        chk($sformatf("a_edge@%0d", edges), a_edge, exp_a);
        chk($sformatf("b_edge@%0d", edges), b_edge, exp_b);
        if (pe_enable) en_cnt++;
        if (in_ready)  rdy_cnt++;
        if (done) begin
            done_cnt++;
            done_at = edges;
        end
    endtask

    // Inputs are already set; record acceptance into the scoreboard, clock
    // once, then check the new cycle at the falling edge.
    task automatic step();
        logic acc;
        acc = in_valid && in_ready;
        if (acc) begin
            for (int i = 0; i < N; i++) begin
                q.push_back('{due: edges + 1 + i, lane: i, a: a_vec[i*DW +: DW], b: b_vec[i*DW +: DW]});
            end
        end
        last_acc = acc;
        @(posedge clk);
        edges++;
        @(negedge clk);
        check_edges();
    endtask

    task automatic run_job(input int idx);
        job_t j;
        int b, gap_left, budget, cnt, s_edge;
        j = jobs[idx];

        pe_clr = 1'b1;
        step();
        step();
        pe_clr = 1'b0;
        en_cnt = 0; rdy_cnt = 0; done_cnt = 0; done_at = -1;

        start = 1'b1;
        cfg_k = KW'(j.k);
        step();
        s_edge = edges;
        start = 1'b0;
        cfg_k = 16'h5A5A;
        chk($sformatf("job%0d_busy_after_start", idx), busy, 1);

        b = 0; gap_left = 0; budget = 0;
        while (b < j.k && budget < 200) begin
            if (gap_left > 0) begin
                in_valid = 1'b0;
                a_vec    = GARB;
                b_vec    = ~GARB;
                gap_left--;
            end else begin
                in_valid = 1'b1;
                a_vec    = beat_vec(j.pat, b, 1'b1);
                b_vec    = beat_vec(j.pat, b, 1'b0);
            end
            step();
            budget++;
            if (last_acc) begin
                b++;
                gap_left = j.gap;
            end
        end
        chk($sformatf("job%0d_beats_accepted", idx), b, j.k);

        // Keep offering garbage: nothing may be accepted outside LOAD.
        in_valid = 1'b1;
        a_vec    = GARB;
        b_vec    = ~GARB;
        cnt = 0;
        while (done_cnt == 0 && cnt < 100) begin
            if (j.poke != 0 && cnt == 2) begin
                start = 1'b1;
                cfg_k = 16'd9;
            end else begin
                start = 1'b0;
            end
            step();
            cnt++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        a_vec    = '0;
        b_vec    = '0;
        repeat (3) step();

        chk($sformatf("job%0d_done_count", idx), done_cnt, 1);
        chk($sformatf("job%0d_done_latency", idx), done_at - s_edge, j.exp_lat);
        chk($sformatf("job%0d_pe_enable_cycles", idx), en_cnt, j.exp_en);
        chk($sformatf("job%0d_in_ready_cycles", idx), rdy_cnt, j.exp_rdy);
        chk($sformatf("job%0d_busy_after_done", idx), busy, 0);
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < N; c++) begin
                chk($sformatf("job%0d_pe_acc_%0d_%0d", idx, i, c), pacc[i][c], exp_acc(j.pat, j.k, i, c));
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // k, gap, pattern, poke, enabled cycles, ready cycles, done latency
        jobs[0] = '{3, 1, 0, 0, 11, 5, 12};   // follows the mid-job reset
        jobs[1] = '{1, 0, 1, 0,  7, 1,  8};   // basic skew
        jobs[2] = '{4, 0, 0, 0, 10, 4, 11};   // identity x (1..16)
        jobs[3] = '{2, 3, 0, 0, 11, 5, 12};   // bubbles between beats
        jobs[4] = '{0, 0, 0, 0,  0, 0,  1};   // empty job
        jobs[5] = '{2, 0, 0, 1,  8, 2,  9};   // start poked during drain

        rst_n = 1'b0; start = 1'b0; cfg_k = '0; in_valid = 1'b0;
        a_vec = '0; b_vec = '0;
        repeat (2) @(negedge clk);
        chk("rst_a_edge", a_edge, 0);
        chk("rst_b_edge", b_edge, 0);
        chk("rst_pe_enable", pe_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;

        // Abort a job in LOAD with an asynchronous reset.
        en_cnt = 0; rdy_cnt = 0; done_cnt = 0; done_at = -1;
        start = 1'b1; cfg_k = 16'd3;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        a_vec = beat_vec(1, 0, 1'b1);
        b_vec = beat_vec(1, 0, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_a_edge", a_edge, 0);
        chk("midrst_b_edge", b_edge, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_pe_enable", pe_enable, 0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0; rdy_cnt = 0; en_cnt = 0;
        repeat (4) step();
        chk("post_rst_no_done", done_cnt, 0);
        chk("post_rst_no_ready", rdy_cnt, 0);
        chk("post_rst_no_enable", en_cnt, 0);

        for (int n = 0; n < 6; n++) begin
            run_job(n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
